// File: rtl/j_chunk_streamer.sv
// J-matrix chunk streamer: fetches one memory word per chunk through a credit-limited
// prefetch FIFO and presents chunks in order over valid/ready. Optional: JCHUNK_CHECKSUM_EN adds chunk_csum.
module j_chunk_streamer #(
  parameter int MEM_BANDWIDTH   = 4096,
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int ADDR_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 2,
  localparam int J_COLS_PER_READ = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH),
  localparam int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ,
  localparam int IDX_W           = $clog2(NUM_J_CHUNKS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_req,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [MEM_BANDWIDTH-1:0] mem_rdata,
  output logic                     chunk_valid,
  input  logic                     chunk_ready,
  output logic [MEM_BANDWIDTH-1:0] chunk_data,
  output logic [IDX_W-1:0]         chunk_idx,
  output logic                     chunk_last
`ifdef JCHUNK_CHECKSUM_EN
  ,
  output logic [31:0]              chunk_csum
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int REQ_W = IDX_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [REQ_W-1:0]         req_cnt;
  logic [IDX_W-1:0]         out_cnt;
  logic [CNT_W-1:0]         outstanding;
  logic [CNT_W-1:0]         fifo_count;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [MEM_BANDWIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic                     done_q;

  logic           start_ok, gnt, hs, last_req;
  logic           fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [CNT_W:0] credit_used;

  assign start_ok   = (state_q == S_IDLE) && start;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH_C[CNT_W-1:0]);
  assign fifo_rd    = chunk_valid && chunk_ready;
  assign hs         = fifo_rd;
  // Responses arriving while idle belong to an abandoned stream and are dropped.
  assign fifo_wr    = mem_rvalid && (state_q != S_IDLE);
  assign last_req   = (req_cnt == REQ_W'(NUM_J_CHUNKS - 1));

  // A slot being read this cycle counts as free; otherwise a latency-1 memory
  // could only sustain two chunks every three cycles with a two-entry FIFO.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, fifo_rd};
  assign mem_req     = (state_q == S_FETCH) && (credit_used < DEPTH_C);
  assign gnt         = mem_req && mem_gnt;
  assign mem_addr    = base_q + ADDR_WIDTH'(req_cnt);

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign chunk_valid = !fifo_empty;
  assign chunk_data  = fifo_mem[rd_ptr];
  assign chunk_idx   = out_cnt;
  assign chunk_last  = chunk_valid && (out_cnt == IDX_W'(NUM_J_CHUNKS - 1));

  // NOTE: every signal driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)           state_d = S_FETCH;
      S_FETCH: if (gnt && last_req) state_d = S_DRAIN;
      S_DRAIN: if (hs && chunk_last) state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      req_cnt     <= '0;
      out_cnt     <= '0;
      outstanding <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= hs && chunk_last;
      if (start_ok) begin
        base_q      <= base_addr;
        req_cnt     <= '0;
        out_cnt     <= '0;
        outstanding <= '0;
      end else begin
        if (gnt) req_cnt <= req_cnt + REQ_W'(1);
        if (hs)  out_cnt <= out_cnt + IDX_W'(1);
        if (gnt && !fifo_wr)      outstanding <= outstanding + CNT_W'(1);
        else if (!gnt && fifo_wr) outstanding <= outstanding - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (start_ok) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({fifo_wr, fifo_rd})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the data array has no reset; its contents are only observed while chunk_valid is high.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= mem_rdata;
  end

  // A response into a full FIFO means one arrived that no credit covered.
  assert property (@(posedge clk) disable iff (rst) !(fifo_wr && fifo_full));

`ifdef JCHUNK_CHECKSUM_EN
  logic [31:0] slice_xor;
  logic [31:0] csum_q;

  always_comb begin
    slice_xor = '0;
    for (int i = 0; i < MEM_BANDWIDTH / 32; i++) slice_xor ^= chunk_data[i*32 +: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           csum_q <= '0;
    else if (start_ok) csum_q <= '0;
    else if (hs)       csum_q <= {csum_q[30:0], csum_q[31]} ^ slice_xor;
  end

  assign chunk_csum = csum_q;
`endif

endmodule
